// File: rtl/sync_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : sync_serial_tx
// Purpose  : Parallel-in, serial-out synchronous transmitter. Accepts a
//            WIDTH-bit word over valid/ready and shifts it out one bit at a
//            time, each bit held for DIV clocks, with an optional trailing
//            even-parity bit. sframe marks the frame window and bit_strobe
//            marks the first clock of every serial bit for the receiver.
// Ports    : clk        - single clock, rising edge
//            rst        - asynchronous, active-high reset
//            in_valid   - word offered on in_data
//            in_data    - parallel word to transmit (WIDTH bits)
//            in_ready   - transmitter can accept a word (IDLE)
//            sdata      - serial data
//            sframe     - high while frame bits are on sdata
//            bit_strobe - high on the first clock of each serial bit
//            busy       - frame in progress (SHIFT or DONE)
//            done       - one-clock pulse after the last bit
// Revision : 1.0 - initial release
// ============================================================================
module sync_serial_tx #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 4,
    parameter int MSB_FIRST = 0,
    parameter int PARITY_EN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             sdata,
    output logic             sframe,
    output logic             bit_strobe,
    output logic             busy,
    output logic             done
);

    // Frame length in serial bits; WIDTH >= 2 keeps this >= 2.
    localparam int c_NBITS = WIDTH + PARITY_EN;
    localparam int c_BIT_W = $clog2(c_NBITS);
    // A divider of 1 still needs a 1-bit counter to keep widths legal.
    localparam int c_DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(c_NBITS - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);
    localparam logic [c_BIT_W-1:0] c_BIT_ONE  = c_BIT_W'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [c_NBITS-1:0] r_shift;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic [c_DIV_W-1:0] r_div_cnt;
    logic               r_in_ready;
    logic               r_sframe;
    logic               r_bit_strobe;
    logic               r_busy;
    logic               r_done;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    logic [1:0]         w_state_nxt;
    logic [c_NBITS-1:0] w_shift_nxt;
    logic [c_BIT_W-1:0] w_bit_cnt_nxt;
    logic [c_DIV_W-1:0] w_div_cnt_nxt;
    logic               w_in_ready_nxt;
    logic               w_sframe_nxt;
    logic               w_bit_strobe_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    // ------------------------------------------------------------------------
    // Frame image in transmit order: bit 0 of w_frame goes out first, so the
    // shifter only ever shifts right regardless of MSB_FIRST. The parity bit,
    // when present, sits at the top and therefore goes out last.
    // ------------------------------------------------------------------------
    logic [c_NBITS-1:0] w_frame;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_order
            if (MSB_FIRST != 0) begin : g_msb
                assign w_frame[gi] = in_data[WIDTH-1-gi];
            end else begin : g_lsb
                assign w_frame[gi] = in_data[gi];
            end
        end
        if (PARITY_EN != 0) begin : g_par
            assign w_frame[WIDTH] = ^in_data;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_div_cnt_nxt    = r_div_cnt;
        w_in_ready_nxt   = r_in_ready;
        w_sframe_nxt     = r_sframe;
        w_busy_nxt       = r_busy;
        // Pulses default low and are raised only on the cycle they mark.
        w_bit_strobe_nxt = 1'b0;
        w_done_nxt       = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                // in_ready is 1 throughout IDLE, so in_valid alone is the
                // handshake here.
                if (in_valid) begin
                    w_state_nxt      = c_ST_SHIFT;
                    w_shift_nxt      = w_frame;
                    w_bit_cnt_nxt    = '0;
                    w_div_cnt_nxt    = '0;
                    w_in_ready_nxt   = 1'b0;
                    w_sframe_nxt     = 1'b1;
                    w_busy_nxt       = 1'b1;
                    w_bit_strobe_nxt = 1'b1;
                end
            end

            c_ST_SHIFT: begin
                if (r_div_cnt == c_DIV_LAST) begin
                    w_div_cnt_nxt = '0;
                    if (r_bit_cnt == c_BIT_LAST) begin
                        // Last clock of the last bit: leave the line low.
                        w_state_nxt  = c_ST_DONE;
                        w_shift_nxt  = '0;
                        w_bit_cnt_nxt = '0;
                        w_sframe_nxt = 1'b0;
                        w_done_nxt   = 1'b1;
                    end else begin
                        w_bit_cnt_nxt    = r_bit_cnt + c_BIT_ONE;
                        w_shift_nxt      = r_shift >> 1;
                        w_bit_strobe_nxt = 1'b1;
                    end
                end else begin
                    w_div_cnt_nxt = r_div_cnt + c_DIV_ONE;
                end
            end

            c_ST_DONE: begin
                w_state_nxt    = c_ST_IDLE;
                w_in_ready_nxt = 1'b1;
                w_busy_nxt     = 1'b0;
            end

            default: begin
                w_state_nxt    = c_ST_IDLE;
                w_shift_nxt    = '0;
                w_bit_cnt_nxt  = '0;
                w_div_cnt_nxt  = '0;
                w_in_ready_nxt = 1'b1;
                w_sframe_nxt   = 1'b0;
                w_busy_nxt     = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_div_cnt    <= '0;
            r_in_ready   <= 1'b1;
            r_sframe     <= 1'b0;
            r_bit_strobe <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_div_cnt    <= w_div_cnt_nxt;
            r_in_ready   <= w_in_ready_nxt;
            r_sframe     <= w_sframe_nxt;
            r_bit_strobe <= w_bit_strobe_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    // The shifter is cleared outside SHIFT, so its LSB is directly the line.
    assign sdata      = r_shift[0];
    assign in_ready   = r_in_ready;
    assign sframe     = r_sframe;
    assign bit_strobe = r_bit_strobe;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sync_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_serial_tx
// Purpose  : Self-checking bench for sync_serial_tx. Three instances cover
//            LSB-first DIV=2, MSB-first DIV=1 and LSB-first DIV=1 with parity.
//            Expected serial bits are queued when a word is offered and
//            popped as the line is sampled on falling edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_serial_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] vld = '0;
    logic [7:0] din [3];
    logic [2:0] rdy, sd, sf, stb, bsy, dn;

    int cfg_div [3] = '{2, 1, 1};
    int cfg_msb [3] = '{0, 1, 0};
    int cfg_par [3] = '{0, 0, 1};

    logic q [$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sync_serial_tx #(.WIDTH(8), .DIV(2), .MSB_FIRST(0), .PARITY_EN(0)) u_a (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .in_data(din[0]),
        .in_ready(rdy[0]), .sdata(sd[0]), .sframe(sf[0]),
        .bit_strobe(stb[0]), .busy(bsy[0]), .done(dn[0]));

    sync_serial_tx #(.WIDTH(8), .DIV(1), .MSB_FIRST(1), .PARITY_EN(0)) u_b (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .in_data(din[1]),
        .in_ready(rdy[1]), .sdata(sd[1]), .sframe(sf[1]),
        .bit_strobe(stb[1]), .busy(bsy[1]), .done(dn[1]));

    sync_serial_tx #(.WIDTH(8), .DIV(1), .MSB_FIRST(0), .PARITY_EN(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(vld[2]), .in_data(din[2]),
        .in_ready(rdy[2]), .sdata(sd[2]), .sframe(sf[2]),
        .bit_strobe(stb[2]), .busy(bsy[2]), .done(dn[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Offer a word on instance s (call at a falling edge while it is IDLE)
    // and queue the serial bits it must produce, each repeated DIV times.
    task automatic offer(input int s, input logic [7:0] w);
        logic b;
        int nb;
        nb = 8 + cfg_par[s];
        vld[s] = 1'b1;
        din[s] = w;
        for (int k = 0; k < nb; k++) begin
            if (k == 8)              b = ^w;
            else if (cfg_msb[s] != 0) b = w[7-k];
            else                     b = w[k];
            for (int r = 0; r < cfg_div[s]; r++) q.push_back(b);
        end
    endtask

    // Check one frame starting at the next rising edge (T0). With hold=1 the
    // source keeps in_valid high and scrambles in_data every cycle.
    task automatic body(input int s, input bit hold);
        int   nb;
        int   dv;
        logic e;
        nb = 8 + cfg_par[s];
        dv = cfg_div[s];
        @(posedge clk);
        for (int i = 0; i < nb * dv; i++) begin
            @(negedge clk);
            if (!hold) vld[s] = 1'b0;
            din[s] = 8'($urandom);
            e = (q.size() > 0) ? q.pop_front() : 1'bx;
            chk("sdata", {31'd0, sd[s]}, {31'd0, e});
            chk("sframe", {31'd0, sf[s]}, 32'd1);
            chk("bit_strobe", {31'd0, stb[s]}, ((i % dv) == 0) ? 32'd1 : 32'd0);
            chk("busy_ready_done", {29'd0, bsy[s], rdy[s], dn[s]}, 32'b100);
        end
        @(negedge clk);
        if (!hold) vld[s] = 1'b0;
        din[s] = 8'($urandom);
        chk("done_cycle", {26'd0, bsy[s], rdy[s], dn[s], sf[s], sd[s], stb[s]}, 32'b101000);
        @(negedge clk);
        chk("ready_cycle", {26'd0, bsy[s], rdy[s], dn[s], sf[s], sd[s], stb[s]}, 32'b010000);
        chk("queue_drained", q.size(), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) din[i] = 8'h00;

        // Reset applied between clock edges with a word offered.
        vld[0] = 1'b1;
        din[0] = 8'hA5;
        #2 rst = 1'b1;
        #1 chk("reset_async", {26'd0, rdy[0], bsy[0], dn[0], sf[0], sd[0], stb[0]}, 32'b100000);
        @(negedge clk);
        vld[0] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_release_ready", {29'd0, rdy}, 32'b111);
        chk("reset_release_sdata", {29'd0, sd}, 32'b000);

        // LSB first, DIV=2: 8'hA5.
        offer(0, 8'hA5);
        body(0, 1'b0);

        // MSB first, DIV=1: 8'h81.
        offer(1, 8'h81);
        body(1, 1'b0);

        // Parity, DIV=1: odd ones count -> parity 1, then even -> parity 0.
        offer(2, 8'h07);
        body(2, 1'b0);
        offer(2, 8'h03);
        body(2, 1'b0);

        // Back-to-back with in_valid held: only the word present at the
        // first IDLE edge may be sent next.
        offer(0, 8'h11);
        body(0, 1'b1);
        offer(0, 8'h5A);
        body(0, 1'b0);

        // Abort during bit 3 of an all-ones word.
        offer(0, 8'hFF);
        @(posedge clk);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            vld[0] = 1'b0;
        end
        chk("abort_pre_bit3", {29'd0, sf[0], sd[0], stb[0]}, 32'b111);
        #1 rst = 1'b1;
        #1 chk("abort_async", {26'd0, rdy[0], bsy[0], dn[0], sf[0], sd[0], stb[0]}, 32'b100000);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_done", {29'd0, dn[0], sf[0], rdy[0]}, 32'b001);
        end

        // New frame after the abort.
        offer(0, 8'h3C);
        body(0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
